// File: rtl/ov7670_capture.sv
// OV7670 parallel-port capture: synchronises the camera pins into clk, pairs
// RGB444 bytes into 12-bit pixels and issues one framebuffer write per pixel.
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              enable,
    input  logic              pclk_pin,
    input  logic              vsync_pin,
    input  logic              href_pin,
    input  logic [7:0]        d_pin,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic              capturing
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0]     X_MAX     = XW'(H_ACTIVE);
    localparam logic [LW-1:0]     L_MAX     = LW'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_WAIT_VE, S_FRAME} state_t;

    state_t state_q, state_d;

    // All pins share one synchroniser chain so pclk, href and data stay aligned.
    logic [10:0] meta_q, sync_q;
    logic        pclk_prev_q, vsync_prev_q, href_prev_q;

    logic [XW-1:0]     x_q, x_d;
    logic [LW-1:0]     line_q, line_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              phase_q, phase_d;
    logic [3:0]        red_q, red_d;
    logic              wr_en_d, frame_done_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [11:0]       wr_data_d;

    logic       pclk_s, vsync_s, href_s;
    logic [7:0] d_s;
    logic       pclk_rise, vsync_rise, vsync_fall, href_fall;

    assign pclk_s  = sync_q[10];
    assign vsync_s = sync_q[9];
    assign href_s  = sync_q[8];
    assign d_s     = sync_q[7:0];

    assign pclk_rise  =  pclk_s  & ~pclk_prev_q;
    assign vsync_rise =  vsync_s & ~vsync_prev_q;
    assign vsync_fall = ~vsync_s &  vsync_prev_q;
    assign href_fall  = ~href_s  &  href_prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            meta_q       <= '0;
            sync_q       <= '0;
            pclk_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
        end else begin
            meta_q       <= {pclk_pin, vsync_pin, href_pin, d_pin};
            sync_q       <= meta_q;
            pclk_prev_q  <= pclk_s;
            vsync_prev_q <= vsync_s;
            href_prev_q  <= href_s;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_WAIT_VS;
            S_WAIT_VS: begin
                if (!enable)      state_d = S_IDLE;
                else if (vsync_s) state_d = S_WAIT_VE;
            end
            S_WAIT_VE: if (vsync_fall) state_d = S_FRAME;
            S_FRAME:   if (vsync_rise) state_d = S_WAIT_VS;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        x_d          = x_q;
        line_d       = line_q;
        base_d       = base_q;
        phase_d      = phase_q;
        red_d        = red_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        frame_done_d = 1'b0;
        capturing    = (state_q == S_FRAME);

        case (state_q)
            S_WAIT_VE: begin
                if (vsync_fall) begin
                    x_d     = '0;
                    line_d  = '0;
                    base_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_FRAME: begin
                frame_done_d = vsync_rise;
                // A line end takes priority over a coincident byte strobe.
                if (href_fall) begin
                    if (x_q != '0 && line_q != L_MAX) begin
                        line_d = line_q + LW'(1);
                        base_d = base_q + LINE_STEP;
                    end
                    x_d     = '0;
                    phase_d = 1'b0;
                end else if (pclk_rise && href_s) begin
                    if (!phase_q) begin
                        red_d   = d_s[3:0];
                        phase_d = 1'b1;
                    end else begin
                        if (x_q < X_MAX && line_q < L_MAX) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = base_q + ADDR_W'(x_q);
                            wr_data_d = {red_q, d_s};
                        end
                        if (x_q != X_MAX) x_d = x_q + XW'(1);
                        phase_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            x_q        <= '0;
            line_q     <= '0;
            base_q     <= '0;
            phase_q    <= 1'b0;
            red_q      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            x_q        <= x_d;
            line_q     <= line_d;
            base_q     <= base_d;
            phase_q    <= phase_d;
            red_q      <= red_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture: random camera bytes on a small
// 4x2 frame, checked against a per-line pixel/address model.
module tb_ov7670_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset_ = 1'b0;
    logic          enable = 1'b0;
    logic          pclk_pin = 1'b0;
    logic          vsync_pin = 1'b0;
    logic          href_pin = 1'b0;
    logic [7:0]    d_pin = 8'h00;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          frame_done;
    logic          capturing;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .enable     (enable),
        .pclk_pin   (pclk_pin),
        .vsync_pin  (vsync_pin),
        .href_pin   (href_pin),
        .d_pin      (d_pin),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .capturing  (capturing)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed writes and pulses, sampled on the falling edge.
    logic [31:0] got_q[$];
    int fd_count  = 0;
    int overlap   = 0;
    int rst_bad   = 0;
    int cap_count = 0;

    always @(negedge clk) begin
        if (wr_en) got_q.push_back(32'({wr_addr, wr_data}));
        if (frame_done) fd_count++;
        if (wr_en && frame_done) overlap++;
        if (capturing) cap_count++;
        if (!reset_ && (wr_en || frame_done || capturing || wr_addr != '0 || wr_data != '0))
            rst_bad++;
    end

    // Reference model: pixel k of counted line L goes to L*H+k when k<H and L<V.
    logic [31:0] exp_q[$];
    int model_line = 0;
    bit model_on   = 1'b0;

    task automatic cam_cycle(input logic [7:0] b, input logic hr);
        pclk_pin = 1'b0;
        d_pin    = b;
        href_pin = hr;
        #20;
        pclk_pin = 1'b1;
        #20;
    endtask

    task automatic idle_pclk(input int n);
        repeat (n) cam_cycle(8'($urandom), 1'b0);
    endtask

    task automatic reset_mid_line();
        repeat (4) @(negedge clk);
        check("writes_before_reset", got_q.size(), 3);
        reset_ = 1'b0;
        #1;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_capturing", capturing, 0);
        check("rst_mid_frame_done", frame_done, 0);
        check("rst_mid_wr_addr", wr_addr, 0);
        check("rst_mid_wr_data", wr_data, 0);
        repeat (3) @(negedge clk);
        model_on = 1'b0;
        exp_q.delete();
        got_q.delete();
        reset_ = 1'b1;
    endtask

    task automatic send_line(input int n, input bit fixed, input int arm_at, input int rst_at);
        logic [7:0] b, b0;
        b0 = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (i == arm_at) enable = 1'b1;
            if (i == rst_at) reset_mid_line();
            b = fixed ? ((i % 2 == 1) ? 8'hBC : 8'h0A) : 8'($urandom);
            if (i % 2 == 0) b0 = b;
            else if (model_on && (i / 2) < H && model_line < V)
                exp_q.push_back(32'({AW'(model_line * H + i / 2), b0[3:0], b}));
            cam_cycle(b, 1'b1);
        end
        if (model_on && n >= 2 && model_line < V) model_line++;
        idle_pclk(3);
    endtask

    task automatic begin_frame(input bit cap);
        got_q.delete();
        exp_q.delete();
        fd_count   = 0;
        model_on   = cap;
        model_line = 0;
        vsync_pin  = 1'b1;
        idle_pclk(4);
        vsync_pin  = 1'b0;
        idle_pclk(3);
    endtask

    task automatic end_frame(input string name, input int exp_fd);
        int n;
        vsync_pin = 1'b1;
        idle_pclk(4);
        check({name, "_write_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_write%0d", name, i), got_q[i], exp_q[i]);
        check({name, "_frame_done"}, fd_count, exp_fd);
    endtask

    initial begin
        // Reset held while the pins toggle at random.
        for (int i = 0; i < 40; i++) begin
            pclk_pin  = 1'($urandom);
            vsync_pin = 1'($urandom);
            href_pin  = 1'($urandom);
            d_pin     = 8'($urandom);
            enable    = 1'($urandom);
            #10;
        end
        check("reset_outputs_zero", rst_bad, 0);
        {pclk_pin, vsync_pin, href_pin, d_pin, enable} = '0;
        @(negedge clk);
        reset_ = 1'b1;

        // Disabled: a whole frame on the pins produces nothing.
        begin_frame(1'b0);
        send_line(8, 1'b0, -1, -1);
        send_line(8, 1'b0, -1, -1);
        end_frame("idle", 0);
        check("idle_capturing", cap_count, 0);

        // Fixed pattern frame: 8 writes of 0xABC at 0..7.
        enable = 1'b1;
        begin_frame(1'b1);
        check("frame_capturing", capturing, 1);
        send_line(8, 1'b1, -1, -1);
        send_line(8, 1'b1, -1, -1);
        end_frame("fixed", 1);
        if (got_q.size() == 8) check("fixed_last", got_q[7], 32'({19'd7, 12'hABC}));
        else check("fixed_last_present", got_q.size(), 8);

        // Random data frame.
        begin_frame(1'b1);
        send_line(8, 1'b0, -1, -1);
        send_line(8, 1'b0, -1, -1);
        end_frame("random", 1);

        // Oversize lines and an extra line are clipped.
        begin_frame(1'b1);
        for (int l = 0; l < 3; l++) send_line(10, 1'b0, -1, -1);
        end_frame("oversize", 1);

        // Odd-length line; enable drops mid-frame without aborting it.
        begin_frame(1'b1);
        send_line(7, 1'b0, -1, -1);
        enable = 1'b0;
        send_line(8, 1'b0, -1, -1);
        end_frame("odd", 1);

        // Arming during active video: this frame is skipped.
        begin_frame(1'b0);
        send_line(8, 1'b0, 4, -1);
        send_line(8, 1'b0, -1, -1);
        end_frame("armed_mid", 0);
        begin_frame(1'b1);
        send_line(8, 1'b0, -1, -1);
        send_line(8, 1'b0, -1, -1);
        end_frame("after_arm", 1);

        // Asynchronous reset after three writes, then a clean frame.
        begin_frame(1'b1);
        send_line(8, 1'b0, -1, 6);
        send_line(8, 1'b0, -1, -1);
        end_frame("post_reset", 0);
        begin_frame(1'b1);
        send_line(8, 1'b0, -1, -1);
        send_line(8, 1'b0, -1, -1);
        end_frame("restart", 1);

        check("frame_done_with_wr_en", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
